fpa_arbiter: RTL
================

# fpa_arbiter

Round-robin arbiter that shares one pipelined floating-point adder (exponent-difference / align / mantissa-add datapath, fixed latency, no stall) between two requesters. It accepts operand pairs over valid/ready, registers them into the adder input, and carries a tag through a shift register aligned with the adder pipeline. Each result is steered back to the requester that issued it. It sits between the two FP clients and the single shared FPA instance.

## Interface
- LAT, 4: adder pipeline latency in cycles, from `fpa_in_valid` to `fpa_result` valid; ≥1
- W, 32: operand/result width (IEEE-754 single)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  grant enable; low blocks new grants, pipeline keeps draining
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  W  requester 0 operands
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as port 0, for requester 1
- fpa_in_valid  out  1  operands presented to adder (registered)
- fpa_a, fpa_b  out  W  registered operands to adder
- fpa_result  in  W  adder output, valid exactly LAT cycles after `fpa_in_valid`
- rsp0_valid, rsp0_data  out  1, W  result for requester 0 (registered, no backpressure)
- rsp1_valid, rsp1_data  out  1, W  result for requester 1
- inflight  out  $clog2(LAT+3)  operations accepted but not yet returned

## Operation
- Grant is combinational: `reqN_ready = en & grantN`.
  - Exactly one valid requester: it is granted.
  - Both valid: the requester named by priority pointer `ptr` is granted.
  - Neither valid, or `en` = 0: no grant.
- Handshake: a transfer occurs when `reqN_valid & reqN_ready` is high at a rising edge. Requesters hold operands stable until the transfer.
- `ptr` update: after a grant to N, `ptr` ← the other requester. With no grant, `ptr` holds. Repeated single-requester traffic is granted every cycle.
- Issue register: on a transfer, it loads {a, b, valid=1, tag=N}. Otherwise valid=0; a/b hold their previous value.
- Tag pipeline: LAT-stage shift of {valid, tag}, fed from the issue register, advances every cycle unconditionally.
- Return: when the tail stage is valid, `fpa_result` is registered into `rspT_data` and `rspT_valid` is pulsed for one cycle. T is the tail tag. The other rsp port's valid is 0; its data holds.
- `inflight`:
  - +1 on each transfer, −1 on each rsp pulse; both in the same cycle leave it unchanged.
  - Maximum value is LAT+2; with continuous traffic it saturates there without overflow.
- The arbiter never stalls. The adder accepts one operation per cycle, so throughput is 1 op/cycle.

## Timing
- Reset values (asynchronous, while rst_n = 0): `ptr`=0, issue valid=0, all tag stages invalid, `fpa_in_valid`=0, `fpa_a`=`fpa_b`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp0_data`=`rsp1_data`=0, `inflight`=0. Ready outputs follow the combinational grant, forced 0 while in reset.
- Latency: transfer sampled at end of cycle 0 → `fpa_in_valid` cycle 1 → `fpa_result` valid cycle 1+LAT → `rspN_valid` cycle 2+LAT. Total LAT+2.
- Responses return in issue order; per-port order is preserved.
- Reset mid-operation drops all in-flight operations. No rsp pulses occur for them after reset release.
- `en` falling with operations in flight: no new grants; in-flight results still return on schedule and `inflight` drains to 0.
- Valid dropped before grant (both valid, one withdraws same cycle): the grant is computed on current-cycle valids only. No sticky request.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with 3 ops in flight, release → all outputs at reset values; no rsp pulse within 10 cycles; `inflight`=0.
- Single op, LAT=4: req0 a=0x3F800000, b=0x40000000 accepted cycle 0; model adder returns 0x40400000 → `fpa_in_valid` cycle 1; `rsp0_valid` only in cycle 6, `rsp0_data`=0x40400000; `rsp1_valid` stays 0.
- Contention: both requesters valid continuously for 8 cycles from reset → grants alternate 0,1,0,1,…; responses alternate ports starting cycle 6; `inflight` reaches and holds 6.
- Single requester back-to-back: req1 valid 5 cycles, req0 idle → 5 consecutive grants to req1; `rsp1_valid` cycles 6–10 with data in issue order.
- Enable gating: issue 2 ops, drop `en` for 6 cycles with both valid → `req0_ready`=`req1_ready`=0; both results still return; `inflight` 2→0; first grant after `en`=1 goes to `ptr` owner.
- Pointer hold: grant req0 alone, idle 3 cycles, then both valid → req1 granted first.

Source files
------------

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP adder between two requesters.
// Operations are tagged with their requester; the tag rides a shift register matched to the adder.
module fpa_arbiter #(
    parameter int unsigned LAT = 4,
    parameter int unsigned W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     req0_valid,
    input  logic [W-1:0]             req0_a,
    input  logic [W-1:0]             req0_b,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [W-1:0]             req1_a,
    input  logic [W-1:0]             req1_b,
    output logic                     req1_ready,
    output logic                     fpa_in_valid,
    output logic [W-1:0]             fpa_a,
    output logic [W-1:0]             fpa_b,
    input  logic [W-1:0]             fpa_result,
    output logic                     rsp0_valid,
    output logic [W-1:0]             rsp0_data,
    output logic                     rsp1_valid,
    output logic [W-1:0]             rsp1_data,
    output logic [$clog2(LAT+3)-1:0] inflight
);

    localparam int unsigned CntW = $clog2(LAT + 3);

    logic            ptr_q, ptr_d;
    logic            grant0, grant1;
    logic            xfer;
    logic            issue_tag_q;
    logic [LAT-1:0]  stg_valid_q;
    logic [LAT-1:0]  stg_tag_q;
    logic            tail_valid, tail_tag;
    logic            rsp_pulse;
    logic [CntW-1:0] inflight_d;

    // Grant uses only this cycle's valids; ptr breaks ties. Ready is held low during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Issue register: operands hold when idle so the adder inputs do not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpa_in_valid <= 1'b0;
            issue_tag_q  <= 1'b0;
            fpa_a        <= '0;
            fpa_b        <= '0;
        end else begin
            fpa_in_valid <= xfer;
            issue_tag_q  <= grant1;
            if (xfer) begin
                fpa_a <= grant1 ? req1_a : req0_a;
                fpa_b <= grant1 ? req1_b : req0_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= '0;
            stg_tag_q   <= '0;
        end else begin
            stg_valid_q[0] <= fpa_in_valid;
            stg_tag_q[0]   <= issue_tag_q;
            for (int i = 1; i < LAT; i++) begin
                stg_valid_q[i] <= stg_valid_q[i-1];
                stg_tag_q[i]   <= stg_tag_q[i-1];
            end
        end
    end

    assign tail_valid = stg_valid_q[LAT-1];
    assign tail_tag   = stg_tag_q[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= tail_valid & ~tail_tag;
            rsp1_valid <= tail_valid & tail_tag;
            if (tail_valid && !tail_tag) begin
                rsp0_data <= fpa_result;
            end
            if (tail_valid && tail_tag) begin
                rsp1_data <= fpa_result;
            end
        end
    end

    // Each op counts for exactly LAT+2 cycles, so the counter peaks at LAT+2 and cannot wrap.
    assign rsp_pulse = rsp0_valid | rsp1_valid;

    always_comb begin
        inflight_d = inflight;
        if (xfer && !rsp_pulse) begin
            inflight_d = inflight + CntW'(1);
        end else if (!xfer && rsp_pulse) begin
            inflight_d = inflight - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_d;
        end
    end

endmodule
